// File: rtl/detector_sentido.sv
// Vehicle direction detector fed by two debounced presence sensors: tracks
// entry/exit sequences, pulses events and keeps a saturating occupancy count.
module detector_sentido #(
  parameter int MAX_AUTOS = 15,
  parameter int ANCHO     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_a,
  input  logic             sensor_b,
  output logic             entrada,
  output logic             salida,
  output logic             error,
  output logic [ANCHO-1:0] contador,
  output logic             lleno,
  output logic             vacio,
  output logic             ocupado
);

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    E1       = 3'd1,
    E2       = 3'd2,
    E3       = 3'd3,
    S1       = 3'd4,
    S2       = 3'd5,
    S3       = 3'd6,
    INVALIDO = 3'd7
  } estado_t;

  localparam logic [ANCHO-1:0] MAX_CUENTA = ANCHO'(MAX_AUTOS);
  localparam logic [ANCHO-1:0] UNO        = ANCHO'(1);

  estado_t          estado;
  estado_t          estadoSig;
  logic [1:0]       ab;
  logic             eventoEnt;
  logic             eventoSal;
  logic [ANCHO-1:0] cuentaSig;

  function automatic estado_t siguiente(input estado_t s, input logic [1:0] v);
    estado_t n;
    n = s;
    case (s)
      REPOSO: case (v)
        2'b10:   n = E1;
        2'b01:   n = S1;
        2'b11:   n = INVALIDO;
        default: n = REPOSO;
      endcase
      E1: case (v)
        2'b10:   n = E1;
        2'b11:   n = E2;
        2'b00:   n = REPOSO;
        default: n = INVALIDO;
      endcase
      E2: case (v)
        2'b11:   n = E2;
        2'b01:   n = E3;
        2'b10:   n = E1;
        default: n = INVALIDO;
      endcase
      E3: case (v)
        2'b01:   n = E3;
        2'b11:   n = E2;
        2'b00:   n = REPOSO;
        default: n = INVALIDO;
      endcase
      S1: case (v)
        2'b01:   n = S1;
        2'b11:   n = S2;
        2'b00:   n = REPOSO;
        default: n = INVALIDO;
      endcase
      S2: case (v)
        2'b11:   n = S2;
        2'b10:   n = S3;
        2'b01:   n = S1;
        default: n = INVALIDO;
      endcase
      S3: case (v)
        2'b10:   n = S3;
        2'b11:   n = S2;
        2'b00:   n = REPOSO;
        default: n = INVALIDO;
      endcase
      default: n = (v == 2'b00) ? REPOSO : INVALIDO;
    endcase
    return n;
  endfunction

  // Occupancy never wraps: a missed exit must not turn a full lot into an empty one.
  function automatic logic [ANCHO-1:0] incSat(input logic [ANCHO-1:0] c);
    return (c < MAX_CUENTA) ? c + UNO : c;
  endfunction

  function automatic logic [ANCHO-1:0] decSat(input logic [ANCHO-1:0] c);
    return (c != '0) ? c - UNO : c;
  endfunction

  assign ab = {sensor_a, sensor_b};

  always_comb begin
    estadoSig = siguiente(estado, ab);
    eventoEnt = (estado == E3) && (ab == 2'b00);
    eventoSal = (estado == S3) && (ab == 2'b00);
    cuentaSig = contador;
    if (eventoEnt)      cuentaSig = incSat(contador);
    else if (eventoSal) cuentaSig = decSat(contador);
  end

  // Flags are computed from the next count so they change on the same edge as contador.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado   <= REPOSO;
      contador <= '0;
      entrada  <= 1'b0;
      salida   <= 1'b0;
      error    <= 1'b0;
      lleno    <= 1'b0;
      vacio    <= 1'b1;
      ocupado  <= 1'b0;
    end else begin
      estado   <= estadoSig;
      contador <= cuentaSig;
      entrada  <= eventoEnt;
      salida   <= eventoSal;
      error    <= (estadoSig == INVALIDO) && (estado != INVALIDO);
      lleno    <= (cuentaSig == MAX_CUENTA);
      vacio    <= (cuentaSig == '0);
      ocupado  <= (estadoSig != REPOSO);
    end
  end

endmodule

// File: doc/detector_sentido.md
# detector_sentido

Direction detector and occupancy counter fed directly by the two debounced sensor outputs of `sensores` (`botonA_estable`, `botonB_estable`). A vehicle that enters blocks sensor A, then both sensors, then only B. A vehicle that exits produces the mirror sequence. The block tracks each sequence with a state machine, emits one-cycle entry/exit pulses, and keeps a saturating occupancy count with full/empty flags for the display and barrier logic downstream.

## Interface
- `MAX_AUTOS`, default 15: occupancy capacity. Legal range is 1 to 2^`ANCHO`−1.
- `ANCHO`, default 4: width of `contador`.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `sensor_a` input 1: debounced sensor A. 1 means blocked. Synchronous to `clk`.
- `sensor_b` input 1: debounced sensor B. 1 means blocked. Synchronous to `clk`.
- `entrada` output 1: one-cycle pulse when a complete entry sequence finishes.
- `salida` output 1: one-cycle pulse when a complete exit sequence finishes.
- `error` output 1: one-cycle pulse when the FSM enters INVALIDO.
- `contador` output `ANCHO`: current occupancy.
- `lleno` output 1: `contador` == `MAX_AUTOS`.
- `vacio` output 1: `contador` == 0.
- `ocupado` output 1: FSM is not in REPOSO (a passage is in progress).

## Operation
- The sensor pair is sampled as `ab` = {`sensor_a`, `sensor_b`} on every rising edge of `clk`.
- FSM states: REPOSO, E1, E2, E3, S1, S2, S3, INVALIDO.
- REPOSO:
  - 10 → E1, 01 → S1, 11 → INVALIDO, 00 → stay.
- E1:
  - 10 → stay, 11 → E2.
  - 00 → REPOSO. This is an aborted entry and produces no event.
  - 01 → INVALIDO.
- E2:
  - 11 → stay, 01 → E3.
  - 10 → E1. The vehicle backed up.
  - 00 → INVALIDO.
- E3:
  - 01 → stay, 11 → E2.
  - 00 → REPOSO and an entry event.
  - 10 → INVALIDO.
- S1, S2, S3 mirror E1, E2, E3 with A and B swapped:
  - S1: 01 stays, 11 → S2, 00 → REPOSO with no event, 10 → INVALIDO.
  - S2: 11 stays, 10 → S3, 01 → S1, 00 → INVALIDO.
  - S3: 10 stays, 11 → S2, 00 → REPOSO and an exit event, 01 → INVALIDO.
- INVALIDO: 00 → REPOSO. Any other value stays. No event is produced.
- Entry event:
  - `entrada` = 1 for one cycle in every case.
  - `contador` increments only if `contador` < `MAX_AUTOS`. At capacity it holds; there is no wrap.
- Exit event:
  - `salida` = 1 for one cycle in every case.
  - `contador` decrements only if `contador` > 0. At 0 it holds; there is no wrap.
- `error` pulses once for each transition into INVALIDO. Remaining in INVALIDO produces no further pulses.
- Entry and exit events cannot occur on the same edge, because the FSM is a single sequence tracker.

## Timing
- All outputs are registered. There are no combinational paths from the sensor inputs to any output.
- Event latency:
  - On the rising edge that samples `ab` = 00 in E3, the FSM goes to REPOSO, `entrada` rises, and `contador` updates.
  - The pulse and the new count are both visible during the following cycle.
  - `entrada` is low again after the next edge.
  - `salida` behaves the same way from S3.
- `error` rises on the edge that moves the FSM into INVALIDO and lasts exactly one cycle.
- Flags:
  - `lleno` and `vacio` update on the same edge as `contador`; they are registered or derived from the registered count.
  - `ocupado` updates on the same edge as the state register.
- A sensor value held for any number of cycles causes no repeated action. Only changes between the listed codes advance the FSM.
- Reset values: state REPOSO, `contador` = 0, `entrada` = 0, `salida` = 0, `error` = 0, `lleno` = 0, `vacio` = 1, `ocupado` = 0.
- Reset asserted mid-sequence:
  - Immediately clears the state and count with no event.
  - After reset is released, the FSM starts in REPOSO. If the sensors are blocked at that moment, it follows the normal REPOSO transitions (e.g. 11 → INVALIDO and an `error` pulse).

## Test plan
- Reset, then `ab` = 00→10→11→01→00 with each code held 3 cycles → exactly one `entrada` pulse, one cycle wide, one cycle after the 00 sample; `contador` = 1; `vacio` = 0.
- From `contador` = 1, apply 00→01→11→10→00 → one `salida` pulse; `contador` = 0; `vacio` = 1; no `error`.
- Apply 00→10→11→10→00 (backed-up entry) → no pulses; `contador` unchanged; `ocupado` high during the sequence, then 0.
- Apply 16 valid entries with `MAX_AUTOS` = 15 → 16 `entrada` pulses; `contador` stops at 15 with `lleno` = 1. Then apply one exit → `contador` = 14, `lleno` = 0.
- Apply 00→10→01 → one `error` pulse; FSM in INVALIDO. Hold 01 for 5 cycles → no further pulses. Then 00 → REPOSO; `contador` unchanged.
- Assert `reset` during state E2 with `contador` = 5 → all outputs return to their reset values asynchronously. After release with `ab` = 00 → REPOSO and no event.
